// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped write-back write-allocate cache controller; CACHE_INIT_SWEEP_EN adds a post-reset array clear
module cache_ctrl #(
    parameter int WORD_W  = 10,
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [WORD_W-1:0]   cpu_addr,
    input  logic [WORD_W-1:0]   cpu_wdata,
    output logic [WORD_W-1:0]   cpu_rdata,
    output logic                cpu_ready,
    output logic [INDEX_W-1:0]  arr_index,
    input  logic [TAG_W-1:0]    arr_tag_rd,
    input  logic [1:0]          arr_valid_rd,
    input  logic [1:0]          arr_dirty_rd,
    input  logic [2*WORD_W-1:0] arr_rdata,
    output logic [1:0]          arr_we,
    output logic [TAG_W-1:0]    arr_tag_wr,
    output logic [1:0]          arr_valid_wr,
    output logic [1:0]          arr_dirty_wr,
    output logic [2*WORD_W-1:0] arr_wdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [WORD_W-1:0]   mem_addr,
    output logic [2*WORD_W-1:0] mem_wdata,
    input  logic [2*WORD_W-1:0] mem_rdata,
    input  logic                mem_ack
);
    typedef enum logic [2:0] {INIT, IDLE, LOOKUP, WRITEBACK, REFILL} state_t;
    state_t state, next;
    logic [TAG_W-1:0] c_tag;
    logic [INDEX_W-1:0] c_idx, sw_idx;
    logic c_off, c_we;
    logic [WORD_W-1:0] c_wdata;
    logic tag_eq, hit, evict, ack, sweep, sweep_end, st_wr, rf_wr;
    logic [1:0] oh;
    assign tag_eq = arr_tag_rd == c_tag;
    assign hit    = tag_eq && arr_valid_rd[c_off];
    assign evict  = !tag_eq && |(arr_valid_rd & arr_dirty_rd);
    assign ack    = mem_req && mem_ack;
    assign oh     = c_off ? 2'b10 : 2'b01;
    assign st_wr  = !reset && state == LOOKUP && hit && c_we;
    assign rf_wr  = !reset && state == REFILL && ack;
`ifdef CACHE_INIT_SWEEP_EN
    logic [INDEX_W-1:0] cnt;
    assign sweep     = !reset && state == INIT;
    assign sweep_end = cnt == '1;
    assign sw_idx    = cnt;
    // Sweep index walks the array once per cycle while in INIT
    always_ff @(posedge clk) begin
        cnt <= (reset || state != INIT) ? '0 : cnt + 1'b1;
    end
`else
    assign sweep     = 1'b0;
    assign sweep_end = 1'b0;
    assign sw_idx    = '0;
`endif
    // State register
    always_ff @(posedge clk) begin
`ifdef CACHE_INIT_SWEEP_EN
        state <= reset ? INIT : next;
`else
        state <= reset ? IDLE : next;
`endif
    end
    // Next-state logic
    always_comb begin
        next = state;
        case (state)
            INIT:      next = sweep_end ? IDLE : INIT;
            IDLE:      next = (cpu_req && !cpu_ready) ? LOOKUP : IDLE;
            LOOKUP:    next = hit ? IDLE : evict ? WRITEBACK : REFILL;
            WRITEBACK: next = ack ? REFILL : WRITEBACK;
            REFILL:    next = ack ? LOOKUP : REFILL;
            default:   next = IDLE;
        endcase
    end
    // Request capture, CPU response and registered memory transfer control
    always_ff @(posedge clk) begin
        if (reset) begin
            c_tag     <= '0;
            c_idx     <= '0;
            c_off     <= 1'b0;
            c_we      <= 1'b0;
            c_wdata   <= '0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            cpu_ready <= state == LOOKUP && hit;
            if (state == IDLE && cpu_req && !cpu_ready) begin
                c_tag   <= cpu_addr[INDEX_W+1 +: TAG_W];
                c_idx   <= cpu_addr[1 +: INDEX_W];
                c_off   <= cpu_addr[0];
                c_we    <= cpu_we;
                c_wdata <= cpu_wdata;
            end
            if (state == LOOKUP && hit && !c_we)
                cpu_rdata <= c_off ? arr_rdata[2*WORD_W-1:WORD_W] : arr_rdata[WORD_W-1:0];
            if (state == LOOKUP && !hit) begin
                mem_req   <= 1'b1;
                mem_we    <= evict;
                mem_addr  <= {evict ? arr_tag_rd : c_tag, c_idx, 1'b0};
                mem_wdata <= arr_rdata;
            end else if (ack && (state == WRITEBACK || state == REFILL)) begin
                mem_req <= 1'b0;
            end else if (state == REFILL && !mem_req) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= {c_tag, c_idx, 1'b0};
            end
        end
    end
    // Array write port: store hit, refill fill, or init sweep; otherwise idle
    always_comb begin
        arr_index    = sweep ? sw_idx : c_idx;
        arr_we       = sweep ? 2'b11 : st_wr ? oh : rf_wr ? (tag_eq ? oh : 2'b11) : 2'b00;
        arr_tag_wr   = (st_wr || rf_wr) ? c_tag : '0;
        arr_valid_wr = (st_wr || rf_wr) ? arr_we : 2'b00;
        arr_dirty_wr = st_wr ? oh : 2'b00;
        arr_wdata    = st_wr ? {c_wdata, c_wdata} : rf_wr ? mem_rdata : '0;
    end
endmodule
